// File: rtl/ram_lsu_pkg.sv
// rtl/ram_lsu_pkg.sv - shared widths, state encoding and helpers for the load/store unit
`ifndef FULLW
`define FULLW 32
`endif
`ifndef WORD
`define WORD 4
`endif

package ram_lsu_pkg;

  // Three-state sequencer: idle/accept, RAM read data available, RAM write issued
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } lsu_state_e;

  // Width of the byte-lane index within a word (at least one bit)
  function automatic int lane_idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/ram_lsu_if.sv
// rtl/ram_lsu_if.sv - CPU-side request/response bundle for the load/store unit
`ifndef FULLW
`define FULLW 32
`endif

interface ram_lsu_if #(
  parameter int ADDR_BITS = `FULLW
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic                 req_byte;
  logic [ADDR_BITS-1:0] req_addr;
  logic [`FULLW-1:0]    req_wdata;
  logic                 rsp_valid;
  logic [`FULLW-1:0]    rsp_rdata;
  logic                 rsp_err;

  modport master (
    output req_valid, req_we, req_byte, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_byte, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ram_lsu_byte_lane.sv
// rtl/ram_lsu_byte_lane.sv - combinational byte-lane extract and merge for little-endian words
module ram_lsu_byte_lane
  import ram_lsu_pkg::*;
#(
  parameter int BYTE_LANES = 4,
  localparam int LANE_W    = lane_idx_w(BYTE_LANES),
  localparam int W         = 8 * BYTE_LANES
) (
  input  logic [W-1:0]      word_i,
  input  logic [7:0]        byte_i,
  input  logic [LANE_W-1:0] lane_i,
  output logic [W-1:0]      ext_o,
  output logic [W-1:0]      merged_o
);

  // Byte n lives in bits [8n+7:8n]; extract zero-extends, merge replaces that lane only
  always_comb begin
    ext_o    = '0;
    merged_o = word_i;
    for (int n = 0; n < BYTE_LANES; n++) begin
      if (lane_i == LANE_W'(n)) begin
        ext_o[7:0]        = word_i[8*n +: 8];
        merged_o[8*n +: 8] = byte_i;
      end
    end
  end

endmodule

// File: rtl/ram_lsu.sv
// rtl/ram_lsu.sv - load/store unit driving a word RAM; optional LSU_ALIGN_CHK_EN faults misaligned word accesses
`ifndef FULLW
`define FULLW 32
`endif
`ifndef WORD
`define WORD 4
`endif

module ram_lsu
  import ram_lsu_pkg::*;
#(
  parameter int ADDR_BITS  = `FULLW,
  parameter int BYTE_LANES = `WORD
) (
  input  logic              clk,
  input  logic              rst,
  ram_lsu_if.slave          bus,
  output logic [`FULLW-1:0] ram_wa_o,
  output logic [`FULLW-1:0] ram_wd_o,
  output logic              ram_we_o,
  output logic [`FULLW-1:0] ram_ra_o,
  input  logic [`FULLW-1:0] ram_out_i
);

  localparam int W      = `FULLW;
  localparam int LANE_W = lane_idx_w(BYTE_LANES);

  lsu_state_e state_q, state_d;

  // Request fields captured on the accept edge
  logic [ADDR_BITS-1:0] addr_q;
  logic [7:0]           wbyte_q;
  logic                 we_q;
  logic                 byte_q;
  logic                 fault_q;

  // Registered RAM-side and response-side outputs
  logic         ram_we_q,    ram_we_d;
  logic [W-1:0] ram_wa_q,    ram_wa_d;
  logic [W-1:0] ram_wd_q,    ram_wd_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic         rsp_err_q,   rsp_err_d;

  logic         accept;
  logic         misalign_req;
  logic [W-1:0] lane_byte;
  logic [W-1:0] lane_merged;

  function automatic logic [W-1:0] align_addr(input logic [ADDR_BITS-1:0] a);
    logic [ADDR_BITS-1:0] m;
    m             = a;
    m[LANE_W-1:0] = '0;
    return W'(m);
  endfunction

  assign bus.req_ready = (state_q == ST_IDLE);
  assign accept        = bus.req_valid && (state_q == ST_IDLE);

`ifdef LSU_ALIGN_CHK_EN
  // Only word accesses can fault; byte accesses are always naturally aligned
  assign misalign_req = ~bus.req_byte & (|bus.req_addr[LANE_W-1:0]);
`else
  // Low address bits are simply dropped, matching the RAM's word indexing
  assign misalign_req = 1'b0;
`endif

  // Read address follows the live request in IDLE so the RAM samples it on the accept edge
  assign ram_ra_o = (state_q == ST_IDLE) ? align_addr(bus.req_addr) : align_addr(addr_q);

  ram_lsu_byte_lane #(
    .BYTE_LANES (BYTE_LANES)
  ) u_lane (
    .word_i   (ram_out_i),
    .byte_i   (wbyte_q),
    .lane_i   (addr_q[LANE_W-1:0]),
    .ext_o    (lane_byte),
    .merged_o (lane_merged)
  );

  // State register; reset abandons any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: word stores go straight to WRITE, everything else reads the word first
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.req_we && !bus.req_byte && !misalign_req) state_d = ST_WRITE;
          else                                              state_d = ST_READ;
        end
      end
      ST_READ:  state_d = (we_q && byte_q && !fault_q) ? ST_WRITE : ST_IDLE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output next-values: the write strobe and the response pulse each last one cycle
  always_comb begin
    ram_we_d    = 1'b0;
    ram_wa_d    = ram_wa_q;
    ram_wd_d    = ram_wd_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && bus.req_we && !bus.req_byte && !misalign_req) begin
          ram_we_d = 1'b1;
          ram_wa_d = align_addr(bus.req_addr);
          ram_wd_d = bus.req_wdata;
        end
      end
      ST_READ: begin
        if (fault_q) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else if (we_q) begin
          ram_we_d = 1'b1;
          ram_wa_d = align_addr(addr_q);
          ram_wd_d = lane_merged;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = byte_q ? lane_byte : ram_out_i;
        end
      end
      ST_WRITE: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
      end
      default: ;
    endcase
  end

  // Output and request-capture registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_we_q    <= 1'b0;
      ram_wa_q    <= '0;
      ram_wd_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      addr_q      <= '0;
      wbyte_q     <= '0;
      we_q        <= 1'b0;
      byte_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      ram_we_q    <= ram_we_d;
      ram_wa_q    <= ram_wa_d;
      ram_wd_q    <= ram_wd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (accept) begin
        addr_q  <= bus.req_addr;
        wbyte_q <= bus.req_wdata[7:0];
        we_q    <= bus.req_we;
        byte_q  <= bus.req_byte;
        fault_q <= misalign_req;
      end
    end
  end

  assign ram_we_o      = ram_we_q;
  assign ram_wa_o      = ram_wa_q;
  assign ram_wd_o      = ram_wd_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
